// File: rtl/uart_rx.sv
// UART receiver: oversampled by clks_per_bit, LSB-first data, one start and one stop bit.
// Every sample point is timed from the centre of the start bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [12:0]           clks_per_bit,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rxs_q;
  logic [12:0]           cpb_q, cpb_d;
  logic [12:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;

  logic [12:0]           half_tgt;
  logic [12:0]           bit_tgt;
  logic [DATA_WIDTH:0]   shift_in;

  // Targets are compared with ==, and the counter only advances while below
  // them, so even a tiny latched period (wrapping to 8191) still terminates.
  assign half_tgt = (cpb_q >> 1) - 13'd1;
  assign bit_tgt  = cpb_q - 13'd1;
  assign shift_in = {rxs_q, shift_q};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cpb_d       = cpb_q;
    cnt_d       = cnt_q + 13'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d   = START;
          cpb_d     = clks_per_bit;
          bit_idx_d = '0;
        end
      end

      START: begin
        if (cnt_q == half_tgt) begin
          cnt_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == bit_tgt) begin
          cnt_d     = '0;
          shift_d   = shift_in[DATA_WIDTH:1];
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == bit_tgt) begin
          cnt_d = '0;
          if (rxs_q) begin
            valid_d    = 1'b1;
            data_out_d = shift_q;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low break sits here, so it reports only the one frame error.
        cnt_d = '0;
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstn) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      cpb_q       <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cpb_q       <= cpb_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner
// sequences and random frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  logic        clk;
  logic        rstn;
  logic [12:0] clks_per_bit;
  logic        rx;
  logic [7:0]  data_out;
  logic        valid;
  logic        frame_err;
  logic        busy;

  int n_tests;
  int n_fail;
  int valid_cnt;
  int err_cnt;
  int both_cnt;

  logic [7:0] model_data;

  typedef struct {
    int         cpb;
    logic [7:0] data;
    logic       stop;
    int         brk;
    int         gap;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clks_per_bit (clks_per_bit),
    .rx           (rx),
    .data_out     (data_out),
    .valid        (valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid)              valid_cnt++;
    if (frame_err)          err_cnt++;
    if (valid && frame_err) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Serial transmitter: one bit period is cpb cycles; optionally changes the
  // clks_per_bit input partway through the data bits.
  task automatic send_frame(input int cpb, input logic [7:0] data, input logic stop_val,
                            input int brk, input int gap, input int new_cpb);
    clks_per_bit = 13'(cpb);
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == 4 && new_cpb > 0) clks_per_bit = 13'(new_cpb);
      repeat (cpb) @(negedge clk);
    end
    rx = stop_val;
    repeat (cpb + brk) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int v0, input int e0,
                             input int exp_v, input int exp_e, input logic [7:0] exp_d);
    #1;
    check({tag, " valid pulses"}, 32'(valid_cnt - v0), 32'(exp_v));
    check({tag, " frame_err pulses"}, 32'(err_cnt - e0), 32'(exp_e));
    check({tag, " data_out"}, 32'(data_out), 32'(exp_d));
  endtask

  initial begin
    vec_t vecs[7];
    int   v0, e0;

    n_tests = 0; n_fail = 0;
    valid_cnt = 0; err_cnt = 0; both_cnt = 0;
    model_data = 8'h00;

    vecs[0] = '{cpb:16, data:8'hA5, stop:1'b1, brk:0,   gap:40, exp_valid:1, exp_err:0, exp_data:8'hA5};
    vecs[1] = '{cpb:16, data:8'h3C, stop:1'b0, brk:100, gap:40, exp_valid:0, exp_err:1, exp_data:8'hA5};
    vecs[2] = '{cpb:16, data:8'h55, stop:1'b1, brk:0,   gap:40, exp_valid:1, exp_err:0, exp_data:8'h55};
    vecs[3] = '{cpb:10, data:8'h00, stop:1'b1, brk:0,   gap:0,  exp_valid:1, exp_err:0, exp_data:8'h00};
    vecs[4] = '{cpb:10, data:8'hFF, stop:1'b1, brk:0,   gap:30, exp_valid:1, exp_err:0, exp_data:8'hFF};
    vecs[5] = '{cpb:4,  data:8'hC3, stop:1'b1, brk:0,   gap:20, exp_valid:1, exp_err:0, exp_data:8'hC3};
    vecs[6] = '{cpb:13, data:8'h6E, stop:1'b0, brk:0,   gap:30, exp_valid:0, exp_err:1, exp_data:8'hC3};

    // Reset state
    rstn = 1'b0; rx = 1'b1; clks_per_bit = 13'd16;
    repeat (4) @(negedge clk);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset valid", 32'(valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frame table
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(vecs[i].cpb, vecs[i].data, vecs[i].stop, vecs[i].brk, vecs[i].gap, 0);
      check_frame($sformatf("vec%0d", i), v0, e0, vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_data);
    end
    model_data = 8'hC3;

    // Start-bit glitch: 3 clk low at cpb 16 is rejected
    v0 = valid_cnt; e0 = err_cnt;
    clks_per_bit = 13'd16;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch busy during", 32'(busy), 32'h1);
    repeat (5) @(negedge clk);
    check("glitch busy after 8 clk", 32'(busy), 32'h0);
    repeat (40) @(negedge clk);
    check_frame("glitch", v0, e0, 0, 0, model_data);

    // clks_per_bit changed mid-frame: current frame keeps 16, next uses 32
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(16, 8'h96, 1'b1, 0, 40, 32);
    check_frame("cpb switch old", v0, e0, 1, 0, 8'h96);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(32, 8'h69, 1'b1, 0, 40, 0);
    check_frame("cpb switch new", v0, e0, 1, 0, 8'h69);

    // Reset pulse during data bit 4
    v0 = valid_cnt; e0 = err_cnt;
    clks_per_bit = 13'd16;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midreset data_out", 32'(data_out), 32'h0);
    check("midreset valid", 32'(valid), 32'h0);
    check("midreset frame_err", 32'(frame_err), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check_frame("midreset abort", v0, e0, 0, 0, 8'h00);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(16, 8'h81, 1'b1, 0, 40, 0);
    check_frame("after reset", v0, e0, 1, 0, 8'h81);
    model_data = 8'h81;

    // Random frames against the frame-level model
    for (int i = 0; i < 24; i++) begin
      int         cpb, brk, gap;
      logic [7:0] d;
      logic       stop;
      cpb  = int'($urandom_range(30, 10));
      d    = 8'($urandom);
      stop = ($urandom_range(4, 0) != 0);
      brk  = stop ? 0 : int'($urandom_range(60, 0));
      gap  = stop ? int'($urandom_range(cpb, 0)) : int'($urandom_range(cpb, 4));
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(cpb, d, stop, brk, gap, 0);
      if (stop) model_data = d;
      check_frame($sformatf("rand%0d cpb%0d d%0h s%0d", i, cpb, d, stop),
                  v0, e0, stop ? 1 : 0, stop ? 0 : 1, model_data);
    end

    repeat (20) @(negedge clk);
    check("valid and frame_err together", 32'(both_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
